// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - sweeps a two-input gate through {b,a}=00..11 and checks its truth table
module gate_truth_table_checker #(
    parameter logic [3:0] EXPECTED = 4'b1000,
    parameter int         SETTLE   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_table,
    output logic [3:0] o_err_mask
);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic [7:0] cnt, cnt_next;
    logic       sample;
    logic [3:0] final_table;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = DRIVE;
                    idx_next   = 2'd0;
                    cnt_next   = 8'd0;
                end
            end
            DRIVE: begin
                sample = (cnt == LAST_CNT);
                if (sample) begin
                    cnt_next = 8'd0;
                    if (idx == 2'd3) begin
                        state_next = DONE;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Table as it will look after the current sample lands; used for the verdict on the last sample.
    always_comb begin
        final_table      = o_table;
        final_table[idx] = i_y;
    end

    // Drive/status outputs are registered from next-state values so they never glitch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= 8'd0;
            o_a        <= 1'b0;
            o_b        <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_pass     <= 1'b0;
            o_table    <= 4'd0;
            o_err_mask <= 4'd0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            cnt    <= cnt_next;
            o_busy <= (state_next == DRIVE);
            o_done <= (state_next == DONE);
            o_a    <= (state_next == DRIVE) ? idx_next[0] : 1'b0;
            o_b    <= (state_next == DRIVE) ? idx_next[1] : 1'b0;
            if (state == IDLE && i_start) begin
                o_table    <= 4'd0;
                o_pass     <= 1'b0;
                o_err_mask <= 4'd0;
            end
            if (sample) begin
                o_table[idx] <= i_y;
                if (idx == 2'd3) begin
                    o_pass     <= (final_table == EXPECTED);
                    o_err_mask <= final_table ^ EXPECTED;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - table-driven and randomized checks of gate_truth_table_checker
module tb_gate_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i [2];
    logic       y_i     [2];
    logic       a_o     [2];
    logic       b_o     [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [3:0] tbl_o   [2];
    logic [3:0] err_o   [2];

    int tests = 0;
    int fails = 0;
    int settle [2] = '{4, 1};

    always #5 clk = ~clk;

    gate_truth_table_checker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[0]), .i_y(y_i[0]),
        .o_a(a_o[0]), .o_b(b_o[0]), .o_busy(busy_o[0]), .o_done(done_o[0]),
        .o_pass(pass_o[0]), .o_table(tbl_o[0]), .o_err_mask(err_o[0])
    );

    gate_truth_table_checker #(.EXPECTED(4'b1000), .SETTLE(1)) dut_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_i[1]), .i_y(y_i[1]),
        .o_a(a_o[1]), .o_b(b_o[1]), .o_busy(busy_o[1]), .o_done(done_o[1]),
        .o_pass(pass_o[1]), .o_table(tbl_o[1]), .o_err_mask(err_o[1])
    );

    typedef struct {
        logic [3:0] gate;
        logic [3:0] exp_table;
        logic       exp_pass;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called on a negedge; i_start is raised here so the accepting edge is the next posedge (E0).
    task automatic sweep(input int w, input logic [3:0] gate, input logic [3:0] exp_table,
                         input logic exp_pass, input logic [3:0] exp_err,
                         input bit noise, input bit poke);
        int s;
        s = settle[w];
        start_i[w] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 4 * s; j++) begin
            @(negedge clk);
            start_i[w] = poke && (j == 2);
            chk("drive_ab", {b_o[w], a_o[w]}, j / s);
            chk("busy_in_sweep", busy_o[w], 1);
            chk("no_early_done", done_o[w], 0);
            if (noise && ((j + 1) % s) != 0)
                y_i[w] = 1'($urandom);
            else
                y_i[w] = gate[j / s];
        end
        @(negedge clk);
        start_i[w] = poke;
        chk("done_pulse", done_o[w], 1);
        chk("busy_at_done", busy_o[w], 0);
        chk("ab_at_done", {b_o[w], a_o[w]}, 0);
        chk("table", tbl_o[w], exp_table);
        chk("pass", pass_o[w], exp_pass);
        chk("err_mask", err_o[w], exp_err);
        @(negedge clk);
        start_i[w] = 1'b0;
        chk("done_one_cycle", done_o[w], 0);
        chk("idle_after_done", busy_o[w], 0);
        chk("table_hold", tbl_o[w], exp_table);
    endtask

    initial begin
        logic [3:0] g;
        vecs[0] = '{4'b1000, 4'b1000, 1'b1, 4'b0000};
        vecs[1] = '{4'b1110, 4'b1110, 1'b0, 4'b0110};
        vecs[2] = '{4'b0110, 4'b0110, 1'b0, 4'b1110};
        vecs[3] = '{4'b0111, 4'b0111, 1'b0, 4'b1111};
        vecs[4] = '{4'b0000, 4'b0000, 1'b0, 4'b1000};
        vecs[5] = '{4'b0001, 4'b0001, 1'b0, 4'b1001};

        rst_n = 1'b0;
        start_i[0] = 1'b1; start_i[1] = 1'b1;
        y_i[0] = 1'b1;     y_i[1] = 1'b1;

        // Reset held with start requested: nothing may move.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_outputs", {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], tbl_o[0], err_o[0]}, 0);
            chk("rst_busy_fast", busy_o[1], 0);
        end
        rst_n = 1'b1;
        start_i[0] = 1'b0; start_i[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_rst", busy_o[0], 0);
        end

        for (int i = 0; i < 6; i++)
            sweep(0, vecs[i].gate, vecs[i].exp_table, vecs[i].exp_pass, vecs[i].exp_err, 1'b0, 1'b0);

        // OR gate against AND expectation; results must hold while idle.
        sweep(0, 4'b1110, 4'b1110, 1'b0, 4'b0110, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_table", tbl_o[0], 4'b1110);
            chk("hold_err", err_o[0], 4'b0110);
            chk("hold_pass", pass_o[0], 0);
            chk("hold_idle", busy_o[0], 0);
        end

        // Starts during DRIVE and on the done cycle are ignored; start at E0+18 runs normally.
        sweep(0, 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1);
        sweep(0, 4'b1110, 4'b1110, 1'b0, 4'b0110, 1'b0, 1'b0);

        // Reset mid-sweep at E0+6.
        start_i[0] = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            start_i[0] = 1'b0;
            y_i[0] = 1'b1;
        end
        chk("partial_table", tbl_o[0], 4'b0001);
        chk("partial_ab", {b_o[0], a_o[0]}, 2'b01);
        #1 rst_n = 1'b0;
        #1;
        chk("async_clear", {a_o[0], b_o[0], busy_o[0], tbl_o[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done_after_abort", done_o[0], 0);
            chk("idle_after_abort", busy_o[0], 0);
        end
        sweep(0, 4'b1000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0);

        // SETTLE=1 with the gate output stuck low.
        sweep(1, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);

        // Random gates with noise between samples; reference: table is the gate itself.
        for (int i = 0; i < 10; i++) begin
            g = 4'($urandom);
            sweep(0, g, g, g == 4'b1000, g ^ 4'b1000, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            g = 4'($urandom);
            sweep(1, g, g, g == 4'b1000, g ^ 4'b1000, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
